// File: rtl/arbiter_nx1_rr.sv
// N-to-1 round-robin bus arbiter: joins N hart memory ports onto one slave bus,
// holds the grant for the whole transaction, with an optional no-ack watchdog.
module arbiter_nx1_rr #(
  parameter int unsigned N_HARTS = 4,
  parameter int unsigned ID_W    = (N_HARTS > 1) ? $clog2(N_HARTS) : 1,
  parameter int unsigned RVA     = 1,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_HARTS-1:0]     i_bus_en,
  input  logic [N_HARTS-1:0]     i_wr_en,
  input  logic [N_HARTS*32-1:0]  i_wr_data,
  input  logic [N_HARTS*32-1:0]  i_addr,
  input  logic [N_HARTS*4-1:0]   i_byte_en,
  input  logic [N_HARTS-1:0]     i_atomic,
  input  logic [N_HARTS*7-1:0]   i_operation,
  output logic [N_HARTS-1:0]     o_ack,
  output logic [N_HARTS*32-1:0]  o_rd_data,
  output logic [N_HARTS-1:0]     o_err,
  output logic                   o_bus_en,
  output logic                   o_wr_en,
  output logic [31:0]            o_wr_data,
  output logic [31:0]            o_addr,
  output logic [3:0]             o_byte_en,
  output logic                   o_atomic,
  output logic [6:0]             o_operation,
  output logic [ID_W-1:0]        o_id,
  input  logic                   i_ack,
  input  logic [31:0]            i_rd_data
);

  localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam logic [WD_W-1:0] WD_MAX  = '1;
  localparam logic [ID_W:0]   N_EXT   = (ID_W + 1)'(N_HARTS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   g_q, g_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic [N_HARTS-1:0] req_rot;
  logic [ID_W:0]      cand;
  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;

  logic               sel_bus_en;
  logic               sel_wr_en;
  logic [31:0]        sel_wr_data;
  logic [31:0]        sel_addr;
  logic [3:0]         sel_byte_en;
  logic               sel_atomic;
  logic [6:0]         sel_operation;

  logic [ID_W:0]      g_inc;
  logic [ID_W-1:0]    g_next;
  logic               wd_fire;

  // Round-robin pick: rotate requests so bit 0 is the hart at ptr, take first set.
  always_comb begin
    req_rot    = N_HARTS'({i_bus_en, i_bus_en} >> ptr_q);
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < N_HARTS; i++) begin
      if (!pick_found && req_rot[i]) begin
        pick_found = 1'b1;
        cand       = {1'b0, ptr_q} + (ID_W + 1)'(i);
        if (cand >= N_EXT) begin
          cand = cand - N_EXT;
        end
        pick_idx = ID_W'(cand);
      end
    end
  end

  // Mux of the currently granted hart's request fields.
  always_comb begin
    sel_bus_en    = 1'b0;
    sel_wr_en     = 1'b0;
    sel_wr_data   = '0;
    sel_addr      = '0;
    sel_byte_en   = '0;
    sel_atomic    = 1'b0;
    sel_operation = '0;
    for (int unsigned k = 0; k < N_HARTS; k++) begin
      if (g_q == ID_W'(k)) begin
        sel_bus_en    = i_bus_en[k];
        sel_wr_en     = i_wr_en[k];
        sel_wr_data   = i_wr_data[32*k +: 32];
        sel_addr      = i_addr[32*k +: 32];
        sel_byte_en   = i_byte_en[4*k +: 4];
        sel_atomic    = i_atomic[k];
        sel_operation = i_operation[7*k +: 7];
      end
    end
  end

  always_comb begin
    g_inc  = {1'b0, g_q} + (ID_W + 1)'(1);
    g_next = (g_inc == N_EXT) ? '0 : ID_W'(g_inc);
  end

  // Next-state and bus outputs; everything is zero while idle.
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    ptr_d       = ptr_q;
    wd_d        = wd_q;
    wd_fire     = 1'b0;
    o_ack       = '0;
    o_rd_data   = '0;
    o_err       = '0;
    o_bus_en    = 1'b0;
    o_wr_en     = 1'b0;
    o_wr_data   = '0;
    o_addr      = '0;
    o_byte_en   = '0;
    o_atomic    = 1'b0;
    o_operation = '0;
    o_id        = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          g_d     = pick_idx;
          wd_d    = '0;
        end
      end

      ST_GRANT: begin
        wd_fire     = (TIMEOUT > 0) && (wd_q == WD_LAST) && sel_bus_en && !i_ack;
        o_bus_en    = sel_bus_en && !i_ack && !wd_fire;
        o_wr_en     = sel_wr_en;
        o_wr_data   = sel_wr_data;
        o_addr      = sel_addr;
        o_byte_en   = sel_byte_en;
        o_atomic    = (RVA != 0) ? sel_atomic : 1'b0;
        o_operation = (RVA != 0) ? sel_operation : 7'd0;
        o_id        = g_q;

        for (int unsigned k = 0; k < N_HARTS; k++) begin
          if (g_q == ID_W'(k)) begin
            o_ack[k]              = i_ack || wd_fire;
            o_err[k]              = wd_fire;
            o_rd_data[32*k +: 32] = i_ack ? i_rd_data : 32'd0;
          end
        end

        // Ack, withdrawal and watchdog all end the transaction and advance ptr.
        if (i_ack || !sel_bus_en || wd_fire) begin
          state_d = ST_IDLE;
          ptr_d   = g_next;
        end else if (wd_q != WD_MAX) begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_arbiter_nx1_rr.sv
// Scoreboard bench for arbiter_nx1_rr: a transaction-level model predicts each
// cycle's outputs into a queue that a negedge monitor pops and compares.
module tb_arbiter_nx1_rr;

  localparam int N  = 4;
  localparam int TO = 8;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [3:0]    i_bus_en;
  logic [3:0]    i_wr_en;
  logic [127:0]  i_wr_data;
  logic [127:0]  i_addr;
  logic [15:0]   i_byte_en;
  logic [3:0]    i_atomic;
  logic [27:0]   i_operation;
  logic [3:0]    o_ack;
  logic [127:0]  o_rd_data;
  logic [3:0]    o_err;
  logic          o_bus_en;
  logic          o_wr_en;
  logic [31:0]   o_wr_data;
  logic [31:0]   o_addr;
  logic [3:0]    o_byte_en;
  logic          o_atomic;
  logic [6:0]    o_operation;
  logic [1:0]    o_id;
  logic          i_ack;
  logic [31:0]   i_rd_data;

  always #5 i_clk = ~i_clk;

  arbiter_nx1_rr #(.N_HARTS(N), .RVA(1), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_bus_en(i_bus_en), .i_wr_en(i_wr_en),
    .i_wr_data(i_wr_data), .i_addr(i_addr), .i_byte_en(i_byte_en),
    .i_atomic(i_atomic), .i_operation(i_operation), .o_ack(o_ack),
    .o_rd_data(o_rd_data), .o_err(o_err), .o_bus_en(o_bus_en),
    .o_wr_en(o_wr_en), .o_wr_data(o_wr_data), .o_addr(o_addr),
    .o_byte_en(o_byte_en), .o_atomic(o_atomic), .o_operation(o_operation),
    .o_id(o_id), .i_ack(i_ack), .i_rd_data(i_rd_data)
  );

  typedef struct packed {
    logic         bus_en;
    logic         wr_en;
    logic [31:0]  wdata;
    logic [31:0]  addr;
    logic [3:0]   be;
    logic         atomic;
    logic [6:0]   op;
    logic [1:0]   id;
    logic [3:0]   ack;
    logic [127:0] rd;
    logic [3:0]   err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model: owner = granted hart (-1 when idle), age = cycles spent granted.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_age   = 0;

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    int   g;
    logic to;
    e = '0;
    if (m_owner >= 0) begin
      g        = m_owner;
      to       = (m_age == TO - 1) && i_bus_en[g] && !i_ack;
      e.wr_en  = i_wr_en[g];
      e.wdata  = i_wr_data[32*g +: 32];
      e.addr   = i_addr[32*g +: 32];
      e.be     = i_byte_en[4*g +: 4];
      e.atomic = i_atomic[g];
      e.op     = i_operation[7*g +: 7];
      e.id     = 2'(g);
      e.bus_en = i_bus_en[g] && !i_ack && !to;
      if (i_ack) begin
        e.ack[g]         = 1'b1;
        e.rd[32*g +: 32] = i_rd_data;
      end else if (to) begin
        e.ack[g] = 1'b1;
        e.err[g] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_update();
    int  c;
    bit  found;
    if (!i_rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_age   = 0;
    end else if (m_owner < 0) begin
      found = 0;
      for (int off = 0; off < N; off++) begin
        c = (m_ptr + off) % N;
        if (!found && i_bus_en[c]) begin
          found   = 1;
          m_owner = c;
          m_age   = 0;
        end
      end
    end else begin
      if (i_ack || !i_bus_en[m_owner] || (m_age == TO - 1)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic apply();
    exp_q.push_back(predict());
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_update();
    #1;
  endtask

  task automatic rand_payload();
    i_wr_en     = 4'($urandom);
    i_wr_data   = {$urandom, $urandom, $urandom, $urandom};
    i_addr      = {$urandom, $urandom, $urandom, $urandom};
    i_byte_en   = 16'($urandom);
    i_atomic    = 4'($urandom);
    i_operation = 28'($urandom);
    i_rd_data   = $urandom;
  endtask

  // Monitor: compare every predicted cycle against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("sb_bus_en", 128'(o_bus_en), 128'(e.bus_en));
        cmp("sb_wr_en",  128'(o_wr_en),  128'(e.wr_en));
        cmp("sb_wdata",  128'(o_wr_data), 128'(e.wdata));
        cmp("sb_addr",   128'(o_addr),   128'(e.addr));
        cmp("sb_be",     128'(o_byte_en), 128'(e.be));
        cmp("sb_atomic", 128'(o_atomic), 128'(e.atomic));
        cmp("sb_op",     128'(o_operation), 128'(e.op));
        cmp("sb_id",     128'(o_id),     128'(e.id));
        cmp("sb_ack",    128'(o_ack),    128'(e.ack));
        cmp("sb_rd",     o_rd_data,      e.rd);
        cmp("sb_err",    128'(o_err),    128'(e.err));
      end
    end
  end

  initial begin
    int ids[5];
    int at[5];
    int n;
    int served;

    i_rst = 1'b0; i_bus_en = '0; i_ack = 1'b0;
    rand_payload();
    tick();

    // Reset held with all requests pending, then release.
    i_bus_en = 4'hF;
    apply(); #2;
    cmp("rst_bus_en", 128'(o_bus_en), 128'd0);
    cmp("rst_id", 128'(o_id), 128'd0);
    cmp("rst_ack", 128'(o_ack), 128'd0);
    tick();
    i_rst = 1'b1;
    apply(); #2;
    cmp("rel_idle_bus_en", 128'(o_bus_en), 128'd0);
    tick();
    apply(); #2;
    cmp("rel_grant_id", 128'(o_id), 128'd0);
    cmp("rel_grant_bus_en", 128'(o_bus_en), 128'd1);
    tick();
    i_ack = 1'b1;
    apply(); #2;
    cmp("rel_ack", 128'(o_ack), 128'd1);
    tick();
    i_ack = 1'b0; i_bus_en = '0;
    apply(); tick();

    // Single hart 2 read, slave acks three cycles into the grant.
    i_bus_en = 4'b0100; i_wr_en = '0; i_addr[95:64] = 32'h100;
    apply(); tick();
    apply(); #2;
    cmp("h2_addr", 128'(o_addr), 128'h100);
    cmp("h2_id", 128'(o_id), 128'd2);
    cmp("h2_bus_en", 128'(o_bus_en), 128'd1);
    tick();
    apply(); tick();
    apply(); tick();
    i_ack = 1'b1; i_rd_data = 32'hDEADBEEF;
    apply(); #2;
    cmp("h2_ack", 128'(o_ack), 128'h4);
    cmp("h2_rd", 128'(o_rd_data[95:64]), 128'hDEADBEEF);
    cmp("h2_bus_en_ack", 128'(o_bus_en), 128'd0);
    tick();
    i_ack = 1'b0; i_bus_en = '0;
    apply(); #2;
    cmp("h2_idle_bus_en", 128'(o_bus_en), 128'd0);
    cmp("h2_idle_ack", 128'(o_ack), 128'd0);
    tick();

    // All harts request continuously after a reset; slave acks immediately.
    i_rst = 1'b0; apply(); tick(); i_rst = 1'b1;
    i_bus_en = 4'hF; n = 0;
    for (int k = 0; k < 5; k++) begin ids[k] = -1; at[k] = -100; end
    for (int c = 0; c < 10; c++) begin
      rand_payload();
      i_ack = (m_owner >= 0);
      apply(); #2;
      if (o_ack != 0 && n < 5) begin ids[n] = int'(o_id); at[n] = c; n++; end
      tick();
    end
    for (int k = 0; k < 5; k++) cmp("rr_order", 128'(ids[k]), 128'(k % 4));
    for (int k = 1; k < 5; k++) cmp("rr_gap", 128'(at[k] - at[k-1]), 128'd2);
    i_ack = 1'b0; i_bus_en = '0;
    apply(); tick();

    // Bring ptr to 2 via a hart 1 transaction, then harts 1 and 3, hart 0 joins.
    i_bus_en = 4'b0010; apply(); tick();
    i_ack = 1'b1; apply(); tick();
    i_ack = 1'b0; i_bus_en = 4'b1010; n = 0;
    for (int k = 0; k < 3; k++) ids[k] = -1;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) i_bus_en[0] = 1'b1;
      i_ack = (m_owner >= 0) && (m_age == 1);
      served = i_ack ? m_owner : -1;
      apply(); #2;
      if (o_ack != 0 && n < 3) begin ids[n] = int'(o_id); n++; end
      tick();
      if (served >= 0) i_bus_en[served] = 1'b0;
    end
    cmp("rr2_first", 128'(ids[0]), 128'd3);
    cmp("rr2_second", 128'(ids[1]), 128'd0);
    cmp("rr2_third", 128'(ids[2]), 128'd1);
    i_ack = 1'b0; i_bus_en = '0;
    apply(); tick();

    // Watchdog: hart 1 never acknowledged.
    i_bus_en = 4'b0010; i_rd_data = 32'h12345678;
    for (int c = 0; c <= 8; c++) begin
      apply(); #2;
      if (c == 7) begin
        cmp("wd_early_err", 128'(o_err), 128'd0);
        cmp("wd_early_bus_en", 128'(o_bus_en), 128'd1);
      end
      if (c == 8) begin
        cmp("wd_ack", 128'(o_ack), 128'h2);
        cmp("wd_err", 128'(o_err), 128'h2);
        cmp("wd_rd", 128'(o_rd_data[63:32]), 128'd0);
        cmp("wd_bus_en", 128'(o_bus_en), 128'd0);
      end
      tick();
    end
    i_bus_en = 4'hF;
    apply(); #2;
    cmp("wd_idle_bus_en", 128'(o_bus_en), 128'd0);
    tick();
    i_ack = 1'b1;
    apply(); #2;
    cmp("wd_ptr_id", 128'(o_id), 128'd2);
    tick();
    i_ack = 1'b0; i_bus_en = '0;
    apply(); tick();

    // Hart 0 withdraws mid-grant while hart 1 waits.
    i_bus_en = 4'b0011;
    apply(); tick();
    apply(); #2;
    cmp("wdr_id", 128'(o_id), 128'd0);
    tick();
    i_bus_en = 4'b0010;
    apply(); #2;
    cmp("wdr_ack", 128'(o_ack), 128'd0);
    cmp("wdr_bus_en", 128'(o_bus_en), 128'd0);
    tick();
    apply(); #2;
    cmp("wdr_idle_bus_en", 128'(o_bus_en), 128'd0);
    tick();
    apply(); #2;
    cmp("wdr_next_id", 128'(o_id), 128'd1);
    cmp("wdr_next_bus_en", 128'(o_bus_en), 128'd1);
    tick();
    i_ack = 1'b1; apply(); tick();
    i_ack = 1'b0;

    // Random traffic with sticky requests, sporadic acks and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      rand_payload();
      i_rst = ($urandom_range(0, 99) != 0);
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 7) == 0) i_bus_en[k] = ~i_bus_en[k];
      end
      i_ack = ($urandom_range(0, 5) == 0);
      apply();
      tick();
    end

    @(negedge i_clk);
    #1;
    cmp("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
